control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Moore-FSM control unit for the 32-bit datapath. Fetches from memory via a Read/Write + mem_ack
//  handshake, decodes ir[31:27], and drives the register select/encode strobes (Gra/Grb/Grc,
//  Rin/Rout/BAout), the bus-source/load strobes and alu_op, one micro-step per clock.
// PARAMETERS
//  RESET_CYCLES  2   cycles held in S_RESET after reset release before the first fetch (>=1)
//  ADD_OP        5'b00011  alu_op driven for address/PC arithmetic
//  MEM_TIMEOUT   15  max cycles waiting for mem_ack (used only with CU_MEM_TIMEOUT_EN)
// PORTS
//  clk       in   1   rising-edge clock
//  reset_n   in   1   asynchronous reset, active low
//  ir        in   32  IR contents; opcode = ir[31:27]
//  con_ff    in   1   branch condition flip-flop output
//  mem_ack   in   1   memory completed the current Read/Write
//  stop      in   1   request halt at next instruction boundary
//  Gra,Grb,Grc,Rin,Rout,BAout     out 1  to select/encode block
//  PCout,PCin,IncPC,MARin,MDRin,MDRout,IRin,Yin,Zin,Zlowout,Cout,CONin  out 1  datapath strobes
//  Read,Write  out 1  memory request, held until mem_ack
//  alu_op    out  5   ALU operation code
//  run       out  1   1 = executing; 0 = in reset hold or halted
//  illegal   out  1   1-cycle pulse on unsupported opcode
//  fault     out  1   memory timeout (CU_MEM_TIMEOUT_EN only; tied 0 otherwise)
// BEHAVIOUR
//  - Reset (async): state=S_RESET, reset counter=0, every output 0 immediately, incl. run.
//  - S_RESET: counts RESET_CYCLES, then T0; run=1 from T0.
//  - Fetch: T0 PCout,MARin,IncPC,Zin | T1 Zlowout,PCin,Read,MDRin (hold in T1 until mem_ack) |
//    T2 MDRout,IRin | T3 first execute step (opcode decoded from ir, registered at T2).
//  - Reg ALU (add,sub,and,or,shr,shl,ror,rol): T3 Grb,Rout,Yin | T4 Grc,Rout,Zin,alu_op=opcode |
//    T5 Zlowout,Gra,Rin -> T0.
//  - Imm ALU (addi,andi,ori): T3 Grb,Rout,Yin | T4 Cout,Zin,alu_op=opcode | T5 Zlowout,Gra,Rin.
//  - ldi: T3 Grb,BAout,Yin | T4 Cout,Zin,alu_op=ADD_OP | T5 Zlowout,Gra,Rin.
//  - ld: ldi T3-T4 | T5 Zlowout,MARin | T6 Read,MDRin (hold until mem_ack) | T7 MDRout,Gra,Rin.
//  - st: ldi T3-T4 | T5 Zlowout,MARin | T6 Gra,Rout,MDRin | T7 Write (hold until mem_ack).
//  - br: T3 Gra,Rout,CONin | T4 PCout,Yin | T5 Cout,Zin,alu_op=ADD_OP | T6 Zlowout; PCin iff con_ff.
//  - jr: T3 Gra,Rout,PCin. nop: T3 no strobes. halt: T3 -> S_HALT.
//  - Other opcodes: illegal=1 during T3, no strobes, then T0.
//  - alu_op = 0 outside the steps listed above. At most one of Gra/Grb/Grc per cycle.
//  - mem_ack in the first Read/Write cycle -> advance next clock (1-cycle access).
//    mem_ack outside a Read/Write step is ignored.
//  - stop sampled only on the last step of an instruction. If 1 -> S_HALT, else T0.
//  - S_HALT: run=0, all strobes 0, stays until reset_n low.
//  - Reset mid-instruction or mid-handshake aborts immediately; Read/Write drop asynchronously.
// CONFIGURATION
//  CU_MEM_TIMEOUT_EN defined:
//    - Wait counter clears on entry to each Read/Write step and counts while mem_ack=0.
//    - Reaching MEM_TIMEOUT -> S_HALT with fault=1 (sticky until reset).
//  CU_MEM_TIMEOUT_EN undefined:
//    - No counter; waits indefinitely; fault=0.
// TESTING
//  1 Reset: reset_n=0 mid-T4 -> all outputs 0 at once; release -> run=1 after 2 clk; T0 shows PCout,MARin,IncPC,Zin.
//  2 add (ir=0x19980000, ack same cycle) -> T3 Grb,Rout,Yin; T4 Grc,Rout,Zin,alu_op=00011; T5 Gra,Rin; 6 clk total.
//  3 ld, mem_ack delayed 3 clk in T6 -> Read,MDRin held 4 clk; MDRout,Gra,Rin exactly one clk later.
//  4 br, con_ff=0 then 1 -> T6 PCin=0 then PCin=1; CONin only in T3.
//  5 stop=1 during add T4 -> add completes; S_HALT with run=0. halt opcode -> same. opcode 11111 -> illegal 1 clk.
//  6 CU_MEM_TIMEOUT_EN, mem_ack never asserted in T1 -> fault=1, run=0 after 15 wait clk.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: Moore-FSM control unit for the 32-bit datapath.
// Fetches an instruction through a Read/Write + mem_ack handshake, decodes
// ir[31:27] and issues one micro-step of datapath strobes per clock.
// Optional build macro: CU_MEM_TIMEOUT_EN enables a memory-wait watchdog
// that halts the sequencer with fault=1 after MEM_TIMEOUT unacknowledged clocks.
module control_sequencer #(
  parameter int unsigned RESET_CYCLES = 2,        // cycles held in S_RESET (1..256)
  parameter logic [4:0]  ADD_OP       = 5'b00011, // alu_op for address/PC arithmetic
  parameter int unsigned MEM_TIMEOUT  = 15        // watchdog limit (1..256)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ack,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal,
  output logic        fault
);

  // Sequencer states
  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] T0      = 4'd1;
  localparam logic [3:0] T1      = 4'd2;
  localparam logic [3:0] T2      = 4'd3;
  localparam logic [3:0] T3      = 4'd4;
  localparam logic [3:0] T4      = 4'd5;
  localparam logic [3:0] T5      = 4'd6;
  localparam logic [3:0] T6      = 4'd7;
  localparam logic [3:0] T7      = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  // Opcodes that this sequencer implements
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011; // first register ALU op
  localparam logic [4:0] OP_OR   = 5'b01010; // last register ALU op
  localparam logic [4:0] OP_ADDI = 5'b01011; // first immediate ALU op
  localparam logic [4:0] OP_ORI  = 5'b01101; // last immediate ALU op
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);

  logic [3:0] state_reg, state_next;
  logic [7:0] rst_cnt_reg;
  logic [4:0] opcode_reg;
  logic [3:0] finish_state;

  logic is_ld, is_ldi, is_st, is_alu, is_imm, is_br, is_jr, is_nop, is_halt, is_bad;

  // Only the opcode field steers the sequencer; register fields go to select/encode.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[26:0];

  // Instruction class of the opcode captured during T2
  always_comb begin
    is_ld   = (opcode_reg == OP_LD);
    is_ldi  = (opcode_reg == OP_LDI);
    is_st   = (opcode_reg == OP_ST);
    is_alu  = (opcode_reg >= OP_ADD) && (opcode_reg <= OP_OR);
    is_imm  = (opcode_reg >= OP_ADDI) && (opcode_reg <= OP_ORI);
    is_br   = (opcode_reg == OP_BR);
    is_jr   = (opcode_reg == OP_JR);
    is_nop  = (opcode_reg == OP_NOP);
    is_halt = (opcode_reg == OP_HALT);
    is_bad  = !(is_ld || is_ldi || is_st || is_alu || is_imm ||
                is_br || is_jr || is_nop || is_halt);
  end

  // The last step of every instruction honours a pending stop request.
  assign finish_state = stop ? S_HALT : T0;

`ifdef CU_MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] wait_cnt_reg;
  logic       fault_reg;
  logic       mem_step;
  logic       timeout_hit;

  // Read/Write steps are never back to back, so the counter is cleared in any
  // other step and therefore starts at zero on entry to each of them.
  assign mem_step    = (state_reg == T1) || ((state_reg == T6) && is_ld) ||
                       ((state_reg == T7) && is_st);
  assign timeout_hit = mem_step && !mem_ack && (wait_cnt_reg == WAIT_LAST);
  assign fault       = fault_reg;

  // Memory wait watchdog; fault stays set until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_reg <= 8'd0;
      fault_reg    <= 1'b0;
    end else begin
      if (!mem_step)
        wait_cnt_reg <= 8'd0;
      else if (!mem_ack)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      if (timeout_hit)
        fault_reg <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (MEM_TIMEOUT == 0);
  assign fault = 1'b0;
`endif

  // Next micro-step
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RESET: if (rst_cnt_reg == RST_LAST) state_next = T0;
      T0:      state_next = T1;
      T1:      if (mem_ack) state_next = T2;
      T2:      state_next = T3;
      T3: begin
        if (is_halt)
          state_next = S_HALT;
        else if (is_alu || is_imm || is_ldi || is_ld || is_st || is_br)
          state_next = T4;
        else
          state_next = finish_state;
      end
      T4:      state_next = T5;
      T5:      state_next = (is_ld || is_st || is_br) ? T6 : finish_state;
      T6: begin
        if (is_br)
          state_next = finish_state;
        else if (is_st || mem_ack)
          state_next = T7;
      end
      T7: begin
        if (is_ld || mem_ack)
          state_next = finish_state;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
`ifdef CU_MEM_TIMEOUT_EN
    if (timeout_hit)
      state_next = S_HALT;
`endif
  end

  // State, reset-hold counter and opcode capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_RESET;
      rst_cnt_reg <= 8'd0;
      opcode_reg  <= 5'd0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_RESET) && (rst_cnt_reg != RST_LAST))
        rst_cnt_reg <= rst_cnt_reg + 8'd1;
      if (state_reg == T2)
        opcode_reg <= ir[31:27];
    end
  end

  // Strobe decode: outputs depend on the state (and con_ff for the branch commit)
  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
    MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Cout = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
    alu_op  = 5'd0;
    illegal = 1'b0;
    run     = (state_reg >= T0) && (state_reg <= T7);
    case (state_reg)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (is_alu || is_imm) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end else if (is_jr) begin
          Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
        end else if (is_bad) begin
          illegal = 1'b1;
        end
      end
      T4: begin
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode_reg;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = opcode_reg;
        end else if (is_ldi || is_ld || is_st) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      T5: begin
        if (is_alu || is_imm || is_ldi) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_ld || is_st) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1; alu_op = ADD_OP;
        end
      end
      T6: begin
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = con_ff;
        end
      end
      T7: begin
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer with hand-computed strobe patterns.
// Build with CU_MEM_TIMEOUT_EN defined to exercise the memory watchdog.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] ir = 32'd0;
  logic        con_ff = 1'b0;
  logic        mem_ack = 1'b0;
  logic        stop = 1'b0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin, MDRin;
  logic MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write;
  logic [4:0] alu_op;
  logic run, illegal, fault;

  int n_total = 0;
  int n_bad   = 0;

  control_sequencer dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .con_ff(con_ff), .mem_ack(mem_ack),
    .stop(stop), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write),
    .alu_op(alu_op), .run(run), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  // Strobe bus packed for compact comparison
  logic [19:0] strb;
  assign strb = {Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, MARin,
                 MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin, Read, Write};

  localparam logic [19:0] M_GRA  = 20'd1 << 19;
  localparam logic [19:0] M_GRB  = 20'd1 << 18;
  localparam logic [19:0] M_GRC  = 20'd1 << 17;
  localparam logic [19:0] M_RIN  = 20'd1 << 16;
  localparam logic [19:0] M_ROUT = 20'd1 << 15;
  localparam logic [19:0] M_BA   = 20'd1 << 14;
  localparam logic [19:0] M_PCO  = 20'd1 << 13;
  localparam logic [19:0] M_PCI  = 20'd1 << 12;
  localparam logic [19:0] M_INC  = 20'd1 << 11;
  localparam logic [19:0] M_MAR  = 20'd1 << 10;
  localparam logic [19:0] M_MDRI = 20'd1 << 9;
  localparam logic [19:0] M_MDRO = 20'd1 << 8;
  localparam logic [19:0] M_IRI  = 20'd1 << 7;
  localparam logic [19:0] M_YIN  = 20'd1 << 6;
  localparam logic [19:0] M_ZIN  = 20'd1 << 5;
  localparam logic [19:0] M_ZLO  = 20'd1 << 4;
  localparam logic [19:0] M_COUT = 20'd1 << 3;
  localparam logic [19:0] M_CON  = 20'd1 << 2;
  localparam logic [19:0] M_RD   = 20'd1 << 1;
  localparam logic [19:0] M_WR   = 20'd1 << 0;

  localparam logic [19:0] S_T0 = M_PCO | M_MAR | M_INC | M_ZIN;
  localparam logic [19:0] S_T1 = M_ZLO | M_PCI | M_RD | M_MDRI;
  localparam logic [19:0] S_T2 = M_MDRO | M_IRI;

  localparam logic [31:0] IR_ADD  = 32'h1998_0000; // 00011
  localparam logic [31:0] IR_SUB  = 32'h2000_0000; // 00100
  localparam logic [31:0] IR_LD   = 32'h0080_0000; // 00000
  localparam logic [31:0] IR_LDI  = 32'h0880_0000; // 00001
  localparam logic [31:0] IR_ST   = 32'h1080_0000; // 00010
  localparam logic [31:0] IR_ADDI = 32'h5880_0000; // 01011
  localparam logic [31:0] IR_BR   = 32'h9080_0000; // 10010
  localparam logic [31:0] IR_JR   = 32'h9880_0000; // 10011
  localparam logic [31:0] IR_NOP  = 32'hC800_0000; // 11001
  localparam logic [31:0] IR_HALT = 32'hD000_0000; // 11010
  localparam logic [31:0] IR_BAD  = 32'hF800_0000; // 11111

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_step(input string tag, input logic [19:0] s, input logic [4:0] a,
                             input logic r, input logic ill);
    check({tag, ".strb"}, 32'(strb), 32'(s));
    check({tag, ".alu"}, 32'(alu_op), 32'(a));
    check({tag, ".run"}, 32'(run), 32'(r));
    check({tag, ".ill"}, 32'(illegal), 32'(ill));
  endtask

  // Assert reset asynchronously, check outputs drop at once, release and reach T0.
  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #1;
    expect_step({tag, ".async"}, 20'd0, 5'd0, 1'b0, 1'b0);
    check({tag, ".fault"}, 32'(fault), 32'd0);
    step();
    reset_n = 1'b1;
    mem_ack = 1'b0;
    stop    = 1'b0;
    step();
    expect_step({tag, ".hold"}, 20'd0, 5'd0, 1'b0, 1'b0);
    step();
    $display("txn reset %s", tag);
  endtask

  // From T0 through fetch to T3; waits = extra unacknowledged T1 cycles.
  task automatic do_fetch(input logic [31:0] word, input int waits, input string tag);
    expect_step({tag, ".T0"}, S_T0, 5'd0, 1'b1, 1'b0);
    ir = word;
    step();
    for (int i = 0; i < waits; i++) begin
      expect_step({tag, ".T1w"}, S_T1, 5'd0, 1'b1, 1'b0);
      step();
    end
    expect_step({tag, ".T1"}, S_T1, 5'd0, 1'b1, 1'b0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    expect_step({tag, ".T2"}, S_T2, 5'd0, 1'b1, 1'b0);
    step();
    $display("txn fetch %s ir=%h waits=%0d", tag, word, waits);
  endtask

  initial begin
    #2;
    apply_reset("por");

    // Register ALU: add and sub
    do_fetch(IR_ADD, 0, "add");
    expect_step("add.T3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0); step();
    expect_step("add.T4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b1, 1'b0); step();
    expect_step("add.T5", M_ZLO | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0); step();

    do_fetch(IR_SUB, 1, "sub");
    expect_step("sub.T3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0); step();
    expect_step("sub.T4", M_GRC | M_ROUT | M_ZIN, 5'b00100, 1'b1, 1'b0); step();
    expect_step("sub.T5", M_ZLO | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0); step();

    // Immediate forms
    do_fetch(IR_ADDI, 0, "addi");
    expect_step("addi.T3", M_GRB | M_ROUT | M_YIN, 5'd0, 1'b1, 1'b0); step();
    expect_step("addi.T4", M_COUT | M_ZIN, 5'b01011, 1'b1, 1'b0); step();
    expect_step("addi.T5", M_ZLO | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0); step();

    do_fetch(IR_LDI, 0, "ldi");
    expect_step("ldi.T3", M_GRB | M_BA | M_YIN, 5'd0, 1'b1, 1'b0); step();
    expect_step("ldi.T4", M_COUT | M_ZIN, 5'b00011, 1'b1, 1'b0); step();
    expect_step("ldi.T5", M_ZLO | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0); step();

    // Load with mem_ack delayed three clocks: Read held four clocks
    do_fetch(IR_LD, 0, "ld");
    expect_step("ld.T3", M_GRB | M_BA | M_YIN, 5'd0, 1'b1, 1'b0); step();
    expect_step("ld.T4", M_COUT | M_ZIN, 5'b00011, 1'b1, 1'b0); step();
    expect_step("ld.T5", M_ZLO | M_MAR, 5'd0, 1'b1, 1'b0); step();
    for (int i = 0; i < 3; i++) begin
      expect_step("ld.T6w", M_RD | M_MDRI, 5'd0, 1'b1, 1'b0); step();
    end
    expect_step("ld.T6", M_RD | M_MDRI, 5'd0, 1'b1, 1'b0);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    expect_step("ld.T7", M_MDRO | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0); step();

    // Store, Write held one extra clock
    do_fetch(IR_ST, 2, "st");
    expect_step("st.T3", M_GRB | M_BA | M_YIN, 5'd0, 1'b1, 1'b0); step();
    expect_step("st.T4", M_COUT | M_ZIN, 5'b00011, 1'b1, 1'b0); step();
    expect_step("st.T5", M_ZLO | M_MAR, 5'd0, 1'b1, 1'b0); step();
    expect_step("st.T6", M_GRA | M_ROUT | M_MDRI, 5'd0, 1'b1, 1'b0); step();
    expect_step("st.T7w", M_WR, 5'd0, 1'b1, 1'b0); step();
    expect_step("st.T7", M_WR, 5'd0, 1'b1, 1'b0);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;

    // Branch not taken, then taken
    for (int t = 0; t < 2; t++) begin
      con_ff = (t == 1);
      do_fetch(IR_BR, 0, "br");
      expect_step("br.T3", M_GRA | M_ROUT | M_CON, 5'd0, 1'b1, 1'b0); step();
      expect_step("br.T4", M_PCO | M_YIN, 5'd0, 1'b1, 1'b0); step();
      expect_step("br.T5", M_COUT | M_ZIN, 5'b00011, 1'b1, 1'b0); step();
      expect_step("br.T6", (t == 1) ? (M_ZLO | M_PCI) : M_ZLO, 5'd0, 1'b1, 1'b0); step();
    end
    con_ff = 1'b0;

    do_fetch(IR_JR, 0, "jr");
    expect_step("jr.T3", M_GRA | M_ROUT | M_PCI, 5'd0, 1'b1, 1'b0); step();

    do_fetch(IR_NOP, 0, "nop");
    expect_step("nop.T3", 20'd0, 5'd0, 1'b1, 1'b0); step();

    // Unsupported opcode: one-clock illegal pulse, then next fetch
    do_fetch(IR_BAD, 0, "bad");
    expect_step("bad.T3", 20'd0, 5'd0, 1'b1, 1'b1); step();
    expect_step("bad.next", S_T0, 5'd0, 1'b1, 1'b0);

    // stop raised during T4 of an add: add completes, then halt
    do_fetch(IR_ADD, 0, "stop");
    step();
    stop = 1'b1;
    expect_step("stop.T4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b1, 1'b0); step();
    expect_step("stop.T5", M_ZLO | M_GRA | M_RIN, 5'd0, 1'b1, 1'b0); step();
    expect_step("stop.halt", 20'd0, 5'd0, 1'b0, 1'b0);
    stop = 1'b0;
    step(); step(); step();
    expect_step("stop.stay", 20'd0, 5'd0, 1'b0, 1'b0);

    // halt opcode
    apply_reset("rst_halt");
    do_fetch(IR_HALT, 0, "halt");
    expect_step("halt.T3", 20'd0, 5'd0, 1'b1, 1'b0); step();
    expect_step("halt.S", 20'd0, 5'd0, 1'b0, 1'b0);

    // Reset mid-T4 and mid-handshake
    apply_reset("rst_pre");
    do_fetch(IR_ADD, 0, "abort");
    step();
    #2;
    apply_reset("rst_t4");
    ir = IR_ADD;
    step();
    check("hs.read", 32'(Read), 32'd1);
    #2;
    apply_reset("rst_t1");

    // Fetch with no acknowledge at all
    expect_step("to.T0", S_T0, 5'd0, 1'b1, 1'b0);
    step();
`ifdef CU_MEM_TIMEOUT_EN
    for (int i = 0; i < 14; i++) step();
    expect_step("to.wait14", S_T1, 5'd0, 1'b1, 1'b0);
    check("to.nofault", 32'(fault), 32'd0);
    step();
    expect_step("to.halt", 20'd0, 5'd0, 1'b0, 1'b0);
    check("to.fault", 32'(fault), 32'd1);
    step(); step();
    check("to.sticky", 32'(fault), 32'd1);
`else
    for (int i = 0; i < 20; i++) step();
    expect_step("to.wait20", S_T1, 5'd0, 1'b1, 1'b0);
    check("to.nofault", 32'(fault), 32'd0);
`endif
    $display("txn timeout-check");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
